// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_sched
// Description : Round-robin scheduler in front of a shared 4:1 data selector.
//               Arbitrates four request lines into a registered one-hot grant,
//               drives the selector's S1/S0 pair from that grant, and
//               registers the selected data word with a valid flag.
//
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               req      - request lines of sources 0..3
//               d0..d3   - data words of sources 0..3 (DATA_W bits each)
//               gnt      - registered one-hot grant, zero when idle
//               s1, s0   - registered select pair, binary encode of gnt
//               y        - registered selected data word
//               y_valid  - y carries data of a granted source
//
// Parameters  : DATA_W   - data word width
//               MAX_HOLD - max consecutive grant cycles per owner (1..255)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        gnt,
  output logic              s1,
  output logic              s0,
  output logic [DATA_W-1:0] y,
  output logic              y_valid
);

  // hold counter only has to reach MAX_HOLD-1; keep at least one bit
  localparam int c_HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_HC_W-1:0] c_HOLD_LAST = c_HC_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          sel_q, sel_d;
  logic [c_HC_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   y_q;
  logic                y_valid_q;

  logic                w_win_vld;
  logic [1:0]          w_win_idx;
  logic                w_keep;
  logic [DATA_W-1:0]   w_sel_data;

  // --------------------------------------------------------------------------
  // Winner scan: ptr+1, ptr+2, ptr+3, ptr (mod 4). In GRANT, ptr is the
  // current owner, so the owner naturally ends up with the lowest priority.
  // --------------------------------------------------------------------------
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      if (!w_win_vld && req[ptr_q + 2'(k)]) begin
        w_win_vld = 1'b1;
        w_win_idx = ptr_q + 2'(k);
      end
    end
  end

  // Owner keeps the grant while it still requests and its hold budget lasts.
  assign w_keep = (state_q == ST_GRANT) && req[ptr_q] && (hold_q < c_HOLD_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    hold_d  = hold_q;

    if (w_keep) begin
      hold_d = hold_q + c_HC_W'(1);
    end else if (w_win_vld) begin
      // re-arbitration (or first grant from IDLE) with no idle bubble
      state_d = ST_GRANT;
      gnt_d   = 4'b0001 << w_win_idx;
      ptr_d   = w_win_idx;
      sel_d   = w_win_idx;
      hold_d  = '0;
    end else begin
      // nobody requests: drop to IDLE, ptr and select keep the last owner
      state_d = ST_IDLE;
      gnt_d   = 4'b0000;
      hold_d  = '0;
    end
  end

  // Selector datapath driven by the registered select pair
  always_comb begin
    case (sel_q)
      2'd0:    w_sel_data = d0;
      2'd1:    w_sel_data = d1;
      2'd2:    w_sel_data = d2;
      default: w_sel_data = d3;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 4'b0000;
      ptr_q     <= 2'd3;      // source 0 wins the first arbitration
      sel_q     <= 2'd0;
      hold_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      // data is captured during a grant cycle, so y lags gnt by one cycle
      if (gnt_q != 4'b0000) begin
        y_q <= w_sel_data;
      end
      y_valid_q <= (gnt_q != 4'b0000);
    end
  end

  assign gnt     = gnt_q;
  assign s1      = sel_q[1];
  assign s0      = sel_q[0];
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_sched
// Description : Self-checking bench for mux_rr_sched with an owner/pointer
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_sched;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [DATA_W-1:0] d0, d1, d2, d3;
  logic [3:0]        gnt;
  logic              s1, s0;
  logic [DATA_W-1:0] y;
  logic              y_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int                m_owner;   // -1 when nobody owns the selector
  int                m_ptr;
  int                m_hold;
  int                m_sel;
  logic [DATA_W-1:0] m_y;
  logic              m_yv;

  mux_rr_sched #(
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .gnt     (gnt),
    .s1      (s1),
    .s0      (s0),
    .y       (y),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int idx);
    case (idx)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_hold  = 0;
    m_sel   = 0;
    m_y     = '0;
    m_yv    = 1'b0;
  endtask

  // One clock edge of the scheduling rules, using the inputs seen at that edge.
  task automatic model_step();
    logic [DATA_W-1:0] ny;
    logic              nyv;
    int                w;
    nyv = (m_owner >= 0);
    ny  = (m_owner >= 0) ? data_of(m_owner) : m_y;
    if (m_owner >= 0 && req[m_owner] && m_hold < MAX_HOLD - 1) begin
      m_hold++;
    end else begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_hold  = 0;
        m_sel   = w;
      end else begin
        m_owner = -1;
      end
    end
    m_y  = ny;
    m_yv = nyv;
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk("gnt", {28'd0, gnt}, {28'd0, eg});
    chk("sel", {30'd0, s1, s0}, 32'(m_sel));
    chk("y", 32'(y), 32'(m_y));
    chk("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
  endtask

  // Drive inputs, take one edge, advance the model, check just after the edge.
  task automatic cycle(input logic [3:0] r);
    req = r;
    d0  = DATA_W'($urandom);
    d1  = DATA_W'($urandom);
    d2  = DATA_W'($urandom);
    d3  = DATA_W'($urandom);
    @(posedge clk);
    model_step();
    #1 check_outputs();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // ---- reset with all sources requesting ----
    rst_n = 1'b0;
    req   = 4'b1111;
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1 check_outputs();
    end
    chk("rst_gnt", {28'd0, gnt}, 32'h0);
    #1 rst_n = 1'b1;

    cycle(4'b1111);
    chk("first_gnt", {28'd0, gnt}, 32'h1);
    cycle(4'b1111);
    chk("first_yv", {31'd0, y_valid}, 32'h1);

    // ---- full contention: rotation in blocks of MAX_HOLD ----
    repeat (18) cycle(4'b1111);

    // ---- single requester re-granted across hold expiry ----
    cycle(4'b0100);
    chk("single_gnt", {28'd0, gnt}, 32'h4);
    repeat (9) cycle(4'b0100);
    chk("single_sel", {30'd0, s1, s0}, 32'h2);

    // ---- idle return and pointer memory ----
    cycle(4'b0000);
    chk("idle_gnt", {28'd0, gnt}, 32'h0);
    cycle(4'b0000);
    chk("idle_yv", {31'd0, y_valid}, 32'h0);
    cycle(4'b0101);
    chk("ptr_mem_gnt", {28'd0, gnt}, 32'h1);

    // ---- early drop by source 1 at hold_cnt=1 ----
    cycle(4'b0010);
    chk("own1_gnt", {28'd0, gnt}, 32'h2);
    cycle(4'b0010);
    cycle(4'b1001);
    chk("early_drop_gnt", {28'd0, gnt}, 32'h8);

    // ---- reset mid-grant ----
    cycle(4'b0010);
    chk("pre_rst_gnt", {28'd0, gnt}, 32'h2);
    cycle(4'b0010);
    async_reset();
    chk("mid_rst_gnt", {28'd0, gnt}, 32'h0);
    chk("mid_rst_yv", {31'd0, y_valid}, 32'h0);
    chk("mid_rst_y", 32'(y), 32'h0);
    cycle(4'b0011);
    chk("post_rst_gnt", {28'd0, gnt}, 32'h1);

    // ---- random traffic with occasional resets ----
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
      end
      if ($urandom_range(0, 7) == 0) cycle(4'b0000);
      else                           cycle(4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
